// File: rtl/softmax_ctrl_seq.sv
// Softmax datapath sequencer: pass 1 (read/exp/accumulate per beat), reciprocal,
// pass 2 (fetch/multiply/store per beat), with start/busy/done and synchronous abort.
module softmax_ctrl_seq #(
  parameter int BEATS    = 8,
  parameter int ADDR_W   = 3,
  parameter int EXP_LAT  = 4,
  parameter int ACC_LAT  = 2,
  parameter int RECI_LAT = 6,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state,
  output logic              o_ram1_rd_en,
  output logic [ADDR_W-1:0] o_ram1_rd_addr,
  output logic              o_ram2_wr_en,
  output logic [ADDR_W-1:0] o_ram2_wr_addr,
  output logic              o_ram2_rd_en,
  output logic [ADDR_W-1:0] o_ram2_rd_addr,
  output logic              o_acc_clr,
  output logic              o_acc_en,
  output logic              o_reci_start,
  output logic              o_ram3_wr_en,
  output logic [ADDR_W-1:0] o_ram3_wr_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXP   = 3'd2,
    S_ACC   = 3'd3,
    S_RECI  = 3'd4,
    S_FETCH = 3'd5,
    S_MUL   = 3'd6,
    S_STORE = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  EXP_LAST  = CNT_W'(EXP_LAT - 1);
  localparam logic [CNT_W-1:0]  ACC_LAST  = CNT_W'(ACC_LAT - 1);
  localparam logic [CNT_W-1:0]  RECI_LAST = CNT_W'(RECI_LAT - 1);
  localparam logic [CNT_W-1:0]  MUL_LAST  = CNT_W'(MUL_LAT - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_beat;
  logic [ADDR_W-1:0] w_nextBeat;
  logic [CNT_W-1:0]  r_latCnt;
  logic              r_done;
  logic              w_lastBeat;

  assign w_lastBeat = (r_beat == LAST_BEAT);

  always_comb begin
    w_nextState = r_state;
    w_nextBeat  = r_beat;
    case (r_state)
      S_IDLE:  if (i_start) w_nextState = S_READ;
      S_READ:  w_nextState = S_EXP;
      S_EXP:   if (r_latCnt == EXP_LAST) w_nextState = S_ACC;
      S_ACC: begin
        if (r_latCnt == ACC_LAST) begin
          if (w_lastBeat) begin
            w_nextState = S_RECI;
            w_nextBeat  = '0;
          end else begin
            w_nextState = S_READ;
            w_nextBeat  = r_beat + 1'b1;
          end
        end
      end
      S_RECI:  if (r_latCnt == RECI_LAST) w_nextState = S_FETCH;
      S_FETCH: w_nextState = S_MUL;
      S_MUL:   if (r_latCnt == MUL_LAST) w_nextState = S_STORE;
      S_STORE: begin
        if (w_lastBeat) begin
          w_nextState = S_IDLE;
          w_nextBeat  = '0;
        end else begin
          w_nextState = S_FETCH;
          w_nextBeat  = r_beat + 1'b1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextBeat  = '0;
      end
    endcase
    if (i_abort) begin
      w_nextState = S_IDLE;
      w_nextBeat  = '0;
    end
  end

  // The latency counter restarts on every state change, so each wait state lasts LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_latCnt <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_beat  <= w_nextBeat;
      if ((w_nextState != r_state) || (r_state == S_IDLE))
        r_latCnt <= '0;
      else
        r_latCnt <= r_latCnt + 1'b1;
      r_done <= (r_state == S_STORE) && w_lastBeat && !i_abort;
    end
  end

  always_comb begin
    o_ram1_rd_en = 1'b0;
    o_ram2_wr_en = 1'b0;
    o_ram2_rd_en = 1'b0;
    o_acc_clr    = 1'b0;
    o_acc_en     = 1'b0;
    o_reci_start = 1'b0;
    o_ram3_wr_en = 1'b0;
    case (r_state)
      S_READ: begin
        o_ram1_rd_en = 1'b1;
        o_acc_clr    = (r_beat == '0);
      end
      S_EXP:   o_ram2_wr_en = (r_latCnt == EXP_LAST);
      S_ACC:   o_acc_en     = (r_latCnt == '0);
      S_RECI:  o_reci_start = (r_latCnt == '0);
      S_FETCH: o_ram2_rd_en = 1'b1;
      S_STORE: o_ram3_wr_en = 1'b1;
      default: ;
    endcase
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_state        = r_state;
  assign o_ram1_rd_addr = r_beat;
  assign o_ram2_wr_addr = r_beat;
  assign o_ram2_rd_addr = r_beat;
  assign o_ram3_wr_addr = r_beat;

endmodule

// File: tb/tb_softmax_ctrl_seq.sv
// Bench for softmax_ctrl_seq: default instance plus a BEATS=2 / latency-1 instance,
// compared every cycle against an arithmetic schedule model.
module tb_softmax_ctrl_seq;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, start2, abort2;
  always #5 clk = ~clk;

  localparam int TA = 102;
  localparam int TB = 13;

  logic       aBusy, aDone, aR1En, aR2wEn, aR2rEn, aAccClr, aAccEn, aReci, aR3En;
  logic [2:0] aState, aR1Addr, aR2wAddr, aR2rAddr, aR3Addr;
  logic       bBusy, bDone, bR1En, bR2wEn, bR2rEn, bAccClr, bAccEn, bReci, bR3En;
  logic [2:0] bState;
  logic [0:0] bR1Addr, bR2wAddr, bR2rAddr, bR3Addr;

  softmax_ctrl_seq dutA (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .o_busy(aBusy), .o_done(aDone), .o_state(aState),
    .o_ram1_rd_en(aR1En), .o_ram1_rd_addr(aR1Addr),
    .o_ram2_wr_en(aR2wEn), .o_ram2_wr_addr(aR2wAddr),
    .o_ram2_rd_en(aR2rEn), .o_ram2_rd_addr(aR2rAddr),
    .o_acc_clr(aAccClr), .o_acc_en(aAccEn), .o_reci_start(aReci),
    .o_ram3_wr_en(aR3En), .o_ram3_wr_addr(aR3Addr)
  );

  softmax_ctrl_seq #(
    .BEATS(2), .ADDR_W(1), .EXP_LAT(1), .ACC_LAT(1), .RECI_LAT(1), .MUL_LAT(1), .CNT_W(2)
  ) dutB (
    .clk(clk), .rst(rst), .i_start(start2), .i_abort(abort2),
    .o_busy(bBusy), .o_done(bDone), .o_state(bState),
    .o_ram1_rd_en(bR1En), .o_ram1_rd_addr(bR1Addr),
    .o_ram2_wr_en(bR2wEn), .o_ram2_wr_addr(bR2wAddr),
    .o_ram2_rd_en(bR2rEn), .o_ram2_rd_addr(bR2rAddr),
    .o_acc_clr(bAccClr), .o_acc_en(bAccEn), .o_reci_start(bReci),
    .o_ram3_wr_en(bR3En), .o_ram3_wr_addr(bR3Addr)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       busy;
    logic       done;
    logic       r1En;
    logic [2:0] r1Addr;
    logic       r2wEn;
    logic [2:0] r2wAddr;
    logic       r2rEn;
    logic [2:0] r2rAddr;
    logic       accClr;
    logic       accEn;
    logic       reciStart;
    logic       r3En;
    logic [2:0] r3Addr;
  } OutVec;

  OutVec actA, actB;
  assign actA = {aState, aBusy, aDone, aR1En, aR1Addr, aR2wEn, aR2wAddr, aR2rEn, aR2rAddr,
                 aAccClr, aAccEn, aReci, aR3En, aR3Addr};
  assign actB = {bState, bBusy, bDone, bR1En, 2'b00, bR1Addr, bR2wEn, 2'b00, bR2wAddr,
                 bR2rEn, 2'b00, bR2rAddr, bAccClr, bAccEn, bReci, bR3En, 2'b00, bR3Addr};

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int posA = 0, posB = 0;
  bit doneA = 0, doneB = 0;

  // Expected outputs at position pos (1 = first READ cycle) of a run, derived from the beat schedule.
  function automatic OutVec expectOut(int pos, bit dn, int b, int e, int a, int r, int m);
    OutVec v;
    int p1, u, o, beat;
    v = '0;
    v.done = dn;
    if (pos == 0) return v;
    v.busy = 1'b1;
    beat = 0;
    p1 = b * (1 + e + a);
    if (pos <= p1) begin
      u = pos - 1; beat = u / (1 + e + a); o = u % (1 + e + a);
      if (o == 0) begin v.st = 3'd1; v.r1En = 1'b1; v.accClr = (beat == 0); end
      else if (o <= e) begin v.st = 3'd2; v.r2wEn = (o == e); end
      else begin v.st = 3'd3; v.accEn = (o == e + 1); end
    end else if (pos <= p1 + r) begin
      v.st = 3'd4; v.reciStart = (pos == p1 + 1);
    end else begin
      u = pos - p1 - r - 1; beat = u / (2 + m); o = u % (2 + m);
      if (o == 0) begin v.st = 3'd5; v.r2rEn = 1'b1; end
      else if (o <= m) v.st = 3'd6;
      else begin v.st = 3'd7; v.r3En = 1'b1; end
    end
    v.r1Addr = 3'(beat); v.r2wAddr = 3'(beat); v.r2rAddr = 3'(beat); v.r3Addr = 3'(beat);
    return v;
  endfunction

  function automatic int nextPos(int pos, bit s, bit ab, int t);
    if (ab) return 0;
    if (pos == 0) return s ? 1 : 0;
    if (pos == t) return 0;
    return pos + 1;
  endfunction

  task automatic checkOutput(string name, OutVec act, OutVec exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s cycle %0d: actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkValue(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s cycle %0d: actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  bit traceOn = 0;
  int rdCyc[8], fetchCyc[8];
  int wrIdx, fetchIdx, stIdx, accCnt, reciCnt;

  // One clock: drive inputs, advance the model, then sample 1 time unit after the edge.
  task automatic applyStimulus(bit s, bit ab, bit s2, bit ab2);
    start = s; abort = ab; start2 = s2; abort2 = ab2;
    @(posedge clk);
    doneA = (posA == TA) && !ab;
    posA  = nextPos(posA, s, ab, TA);
    doneB = (posB == TB) && !ab2;
    posB  = nextPos(posB, s2, ab2, TB);
    #1;
    cyc++;
    checkOutput("modelA", actA, expectOut(posA, doneA, 8, 4, 2, 6, 3));
    checkOutput("modelB", actB, expectOut(posB, doneB, 2, 1, 1, 1, 1));
    if (traceOn) begin
      if (aR1En) rdCyc[aR1Addr] = cyc;
      if (aAccClr) checkValue("accClrBeat", int'(aR1Addr), 0);
      if (aAccEn) accCnt++;
      if (aReci) reciCnt++;
      if (aR2wEn && wrIdx < 8) begin
        checkValue("ram2WrOrder", int'(aR2wAddr), wrIdx);
        checkValue("ram2WrDelay", cyc - rdCyc[wrIdx], 4);
        wrIdx++;
      end
      if (aR2rEn && fetchIdx < 8) begin
        checkValue("ram2RdOrder", int'(aR2rAddr), fetchIdx);
        fetchCyc[fetchIdx] = cyc;
        fetchIdx++;
      end
      if (aR3En && stIdx < 8) begin
        checkValue("ram3WrOrder", int'(aR3Addr), stIdx);
        checkValue("ram3WrDelay", cyc - fetchCyc[stIdx], 4);
        stIdx++;
      end
    end
  endtask

  typedef struct {
    int         n;
    bit         s;
    bit         ab;
    logic [2:0] st;
    bit         busy;
    bit         done;
  } TabRow;

  TabRow tab[16];
  int    n;

  initial begin
    tab[0]  = '{1,  1, 0, 3'd1, 1, 0};
    tab[1]  = '{1,  1, 0, 3'd2, 1, 0};
    tab[2]  = '{4,  1, 0, 3'd3, 1, 0};
    tab[3]  = '{2,  1, 0, 3'd1, 1, 0};
    tab[4]  = '{48, 1, 0, 3'd3, 1, 0};
    tab[5]  = '{1,  1, 0, 3'd4, 1, 0};
    tab[6]  = '{6,  1, 0, 3'd5, 1, 0};
    tab[7]  = '{1,  1, 0, 3'd6, 1, 0};
    tab[8]  = '{3,  1, 0, 3'd7, 1, 0};
    tab[9]  = '{35, 1, 0, 3'd7, 1, 0};
    tab[10] = '{1,  0, 0, 3'd0, 0, 1};
    tab[11] = '{1,  1, 0, 3'd1, 1, 0};
    tab[12] = '{1,  0, 0, 3'd2, 1, 0};
    tab[13] = '{1,  1, 1, 3'd0, 0, 0};
    tab[14] = '{1,  1, 1, 3'd0, 0, 0};
    tab[15] = '{1,  0, 0, 3'd0, 0, 0};

    rst = 1'b1; start = 0; abort = 0; start2 = 0; abort2 = 0;
    @(posedge clk); #1;
    checkOutput("resetA", actA, '0);
    checkOutput("resetB", actB, '0);
    rst = 1'b0;

    // Start held high through a whole run, restart on the done cycle, then abort.
    for (int i = 0; i < 16; i++) begin
      repeat (tab[i].n) applyStimulus(tab[i].s, tab[i].ab, 0, 0);
      checkValue($sformatf("table%0d", i), int'({aState, aBusy, aDone}),
                 int'({tab[i].st, tab[i].busy, tab[i].done}));
    end

    // Abort in MUL at beat 3, then a clean traced rerun.
    applyStimulus(1, 0, 0, 0);
    repeat (79) applyStimulus(0, 0, 0, 0);
    checkValue("preAbortState", int'(aState), 6);
    checkValue("preAbortBeat", int'(aR2rAddr), 3);
    applyStimulus(0, 1, 0, 0);
    checkOutput("abortIdle", actA, '0);
    repeat (3) begin
      applyStimulus(0, 0, 0, 0);
      checkValue("noDoneAfterAbort", int'(aDone), 0);
    end
    traceOn = 1; wrIdx = 0; fetchIdx = 0; stIdx = 0; accCnt = 0; reciCnt = 0;
    applyStimulus(1, 0, 0, 0);
    n = 1;
    while (!aDone && n < 200) begin
      applyStimulus(0, 0, 0, 0);
      n++;
    end
    traceOn = 0;
    checkValue("restartDoneCycle", n, 103);
    checkValue("accEnCount", accCnt, 8);
    checkValue("reciStartCount", reciCnt, 1);
    checkValue("ram2WrCount", wrIdx, 8);
    checkValue("ram3WrCount", stIdx, 8);

    // Asynchronous reset in the middle of ACC with start held high.
    applyStimulus(1, 0, 1, 0);
    repeat (5) applyStimulus(1, 0, 1, 0);
    checkValue("preRstState", int'(aState), 3);
    rst = 1'b1;
    #1;
    posA = 0; doneA = 0; posB = 0; doneB = 0;
    checkOutput("rstAsyncA", actA, '0);
    checkOutput("rstAsyncB", actB, '0);
    @(posedge clk); #1;
    checkOutput("rstHeldA", actA, '0);
    rst = 1'b0;
    applyStimulus(0, 1, 0, 1);

    // Small configuration: 13-cycle run, done on cycle 14.
    applyStimulus(0, 0, 1, 0);
    n = 1;
    while (!bDone && n < 50) begin
      applyStimulus(0, 0, 0, 0);
      n++;
    end
    checkValue("smallDoneCycle", n, 14);

    // Random start/abort traffic on both instances.
    for (int i = 0; i < 4000; i++)
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 80) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 30) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
